// File: rtl/epcs_flash_responder.sv
// EPCS serial-flash responder: decodes READ/ID/STATUS on an oversampled EPCS link, serves bytes from a memory port.
// Optional `EPCS_FAST_READ_EN enables FAST_READ (0x0B) with one dummy byte; otherwise 0x0B is ignored.
module epcs_flash_responder #(
    parameter int          MEM_AW     = 19,
    parameter logic [7:0]  SILICON_ID = 8'h12,
    parameter logic [7:0]  STATUS_VAL = 8'h00
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              epcs_dclk,
    input  logic              epcs_sce,
    input  logic              epcs_sdo,
    output logic              epcs_data0,
    output logic              mem_rd,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [7:0]        mem_rdata
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_CMD    = 4'd1;
    localparam logic [3:0] S_ADDR   = 4'd2;
    localparam logic [3:0] S_DUMMY  = 4'd3;
    localparam logic [3:0] S_ID     = 4'd4;
    localparam logic [3:0] S_STAT   = 4'd5;
    localparam logic [3:0] S_IGNORE = 4'd6;
    localparam logic [3:0] S_DATA   = 4'd7;
    localparam logic [3:0] S_FDUMMY = 4'd8;

    logic [2:0]        dclk_q;
    logic [2:0]        sce_q;
    logic [1:0]        sdo_q;
    logic              dclk_rise;
    logic              dclk_fall;
    logic              sce_fall;
    logic              sce_high;
    logic              sdo_bit;

    logic [3:0]        state;
    logic [2:0]        bit_cnt;
    logic [2:0]        byte_cnt;
    logic [6:0]        rx;
    logic [7:0]        rx_next;
    logic [MEM_AW-1:0] addr;
    logic [MEM_AW-1:0] addr_next;
    logic [7:0]        tx;
    logic [7:0]        hold;
    logic [7:0]        load_byte;
    logic              rd_pend;
    logic              fast;

    // Select is synchronised with a reset value of "selected" so that releasing reset
    // while sce is already low cannot fake a falling edge mid-transfer.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dclk_q <= 3'b000;
            sce_q  <= 3'b000;
            sdo_q  <= 2'b00;
        end else begin
            dclk_q <= {dclk_q[1:0], epcs_dclk};
            sce_q  <= {sce_q[1:0], epcs_sce};
            sdo_q  <= {sdo_q[0], epcs_sdo};
        end
    end

    assign dclk_rise = dclk_q[1] & ~dclk_q[2];
    assign dclk_fall = ~dclk_q[1] & dclk_q[2];
    assign sce_fall  = ~sce_q[1] & sce_q[2];
    assign sce_high  = sce_q[1];
    assign sdo_bit   = sdo_q[1];
    assign rx_next   = {rx, sdo_bit};
    assign addr_next = {addr[MEM_AW-2:0], sdo_bit};

    always_comb begin
        load_byte = 8'h00;
        case (state)
            S_DATA:  load_byte = hold;
            S_ID:    load_byte = SILICON_ID;
            S_STAT:  load_byte = STATUS_VAL;
            default: load_byte = 8'h00;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= S_IDLE;
            bit_cnt    <= 3'd0;
            byte_cnt   <= 3'd0;
            rx         <= 7'd0;
            addr       <= '0;
            tx         <= 8'h00;
            hold       <= 8'h00;
            rd_pend    <= 1'b0;
            fast       <= 1'b0;
            epcs_data0 <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
        end else begin
            mem_rd  <= 1'b0;
            rd_pend <= mem_rd;
            if (rd_pend)
                hold <= mem_rdata;

            if (state == S_IDLE) begin
                bit_cnt    <= 3'd0;
                byte_cnt   <= 3'd0;
                tx         <= 8'h00;
                fast       <= 1'b0;
                epcs_data0 <= 1'b0;
                if (sce_fall)
                    state <= S_CMD;
            end else if (sce_high) begin
                // Deselect drops any partial byte and any prefetch still in flight.
                state      <= S_IDLE;
                bit_cnt    <= 3'd0;
                byte_cnt   <= 3'd0;
                rd_pend    <= 1'b0;
                epcs_data0 <= 1'b0;
            end else if (dclk_rise) begin
                rx      <= rx_next[6:0];
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7 && byte_cnt != 3'd7)
                    byte_cnt <= byte_cnt + 3'd1;

                case (state)
                    S_CMD: begin
                        if (bit_cnt == 3'd7) begin
                            case (rx_next)
                                8'h03:   state <= S_ADDR;
                                8'hAB:   state <= S_DUMMY;
                                8'h05:   state <= S_STAT;
`ifdef EPCS_FAST_READ_EN
                                8'h0B: begin
                                    state <= S_ADDR;
                                    fast  <= 1'b1;
                                end
`endif
                                default: state <= S_IGNORE;
                            endcase
                        end
                    end
                    S_ADDR: begin
                        addr <= addr_next;
                        if (bit_cnt == 3'd7 && byte_cnt == 3'd3) begin
                            mem_rd   <= 1'b1;
                            mem_addr <= addr_next;
                            state    <= fast ? S_FDUMMY : S_DATA;
                        end
                    end
                    S_FDUMMY: begin
                        if (bit_cnt == 3'd7)
                            state <= S_DATA;
                    end
                    S_DUMMY: begin
                        if (bit_cnt == 3'd7 && byte_cnt == 3'd3)
                            state <= S_ID;
                    end
                    S_DATA: begin
                        // Mid-byte prefetch leaves half a byte of dclk for the read to land in hold.
                        if (bit_cnt == 3'd4) begin
                            mem_rd   <= 1'b1;
                            mem_addr <= mem_addr + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else if (dclk_fall) begin
                if (bit_cnt == 3'd0) begin
                    epcs_data0 <= load_byte[7];
                    tx         <= {load_byte[6:0], 1'b0};
                end else begin
                    epcs_data0 <= tx[7];
                    tx         <= {tx[6:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_epcs_flash_responder.sv
// Self-checking bench for epcs_flash_responder: directed plan cases plus random frames against a byte-level model.
module tb_epcs_flash_responder;

    localparam int         MEM_AW = 19;
    localparam logic [7:0] SID    = 8'h12;
    localparam logic [7:0] STAT   = 8'hA5;
    localparam int         HALF   = 5;

    logic              sys_clk   = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              epcs_dclk = 1'b0;
    logic              epcs_sce  = 1'b1;
    logic              epcs_sdo  = 1'b0;
    logic              epcs_data0;
    logic              mem_rd;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_rdata = 8'h00;

    int checks = 0;
    int passed = 0;
    int rd_log[$];

    epcs_flash_responder #(
        .MEM_AW(MEM_AW),
        .SILICON_ID(SID),
        .STATUS_VAL(STAT)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .epcs_dclk(epcs_dclk),
        .epcs_sce(epcs_sce),
        .epcs_sdo(epcs_sdo),
        .epcs_data0(epcs_data0),
        .mem_rd(mem_rd),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata)
    );

    always #10 sys_clk = ~sys_clk;

    // Memory stand-in returns the low address byte one cycle after each strobe.
    always @(posedge sys_clk) begin
        if (mem_rd) begin
            mem_rdata <= mem_addr[7:0];
            rd_log.push_back(int'(mem_addr));
        end
    end

    task automatic check_output(input string tag, input int actual, input int expected);
        checks++;
        if (actual == expected)
            passed++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic xfer_byte(input logic [7:0] tx_b, output logic [7:0] rx_b);
        for (int i = 7; i >= 0; i--) begin
            epcs_sdo = tx_b[i];
            wait_clk(HALF);
            rx_b[i] = epcs_data0;
            epcs_dclk = 1'b1;
            wait_clk(HALF);
            epcs_dclk = 1'b0;
        end
    endtask

    // Model works per byte: header bytes read back as zero, then n reply bytes.
    task automatic apply_stimulus(input logic [7:0] op, input int addr, input int n, input string tag);
        logic [7:0] tx_q[$];
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        int         exp_rd[$];
        logic [7:0] rx_b;
        logic [7:0] fixed;
        logic [23:0] a24;
        int         hdr;
        int         mask;
        int         nrd;
        bit         rd_data;
        mask    = (1 << MEM_AW) - 1;
        a24     = addr[23:0];
        hdr     = 4;
        rd_data = 1'b0;
        fixed   = 8'h00;
        case (op)
            8'h03: rd_data = 1'b1;
            8'h0B: begin
                hdr = 5;
`ifdef EPCS_FAST_READ_EN
                rd_data = 1'b1;
`endif
            end
            8'hAB: fixed = SID;
            8'h05: begin
                hdr   = 1;
                fixed = STAT;
            end
            default: ;
        endcase
        tx_q.push_back(op);
        tx_q.push_back(a24[23:16]);
        tx_q.push_back(a24[15:8]);
        tx_q.push_back(a24[7:0]);
        tx_q.push_back(8'h00);
        while (tx_q.size() < hdr + n) tx_q.push_back(8'($urandom));
        while (tx_q.size() > hdr + n) void'(tx_q.pop_back());
        for (int k = 0; k < hdr; k++) exp_q.push_back(8'h00);
        for (int k = 0; k < n; k++)
            exp_q.push_back(rd_data ? 8'((addr + k) & mask) : fixed);
        if (rd_data)
            for (int k = 0; k <= n; k++) exp_rd.push_back((addr + k) & mask);

        rd_log.delete();
        epcs_sce = 1'b0;
        wait_clk(4);
        foreach (tx_q[k]) begin
            xfer_byte(tx_q[k], rx_b);
            got_q.push_back(rx_b);
        end
        wait_clk(HALF);
        epcs_sce = 1'b1;
        wait_clk(8);

        foreach (exp_q[k])
            check_output($sformatf("%s byte%0d", tag, k), int'(got_q[k]), int'(exp_q[k]));
        check_output({tag, " read count"}, rd_log.size(), exp_rd.size());
        nrd = (rd_log.size() < exp_rd.size()) ? rd_log.size() : exp_rd.size();
        for (int k = 0; k < nrd; k++)
            check_output($sformatf("%s read%0d", tag, k), rd_log[k], exp_rd[k]);
    endtask

    logic [7:0] op_pool[6] = '{8'h03, 8'h03, 8'h0B, 8'hAB, 8'h05, 8'h00};

    initial begin
        logic [7:0] rx_b;
        logic [7:0] op;
        int         idx;

        wait_clk(5);
        check_output("reset data0", int'(epcs_data0), 0);
        check_output("reset mem_rd", int'(mem_rd), 0);
        check_output("reset mem_addr", int'(mem_addr), 0);
        sys_rst_n = 1'b1;
        wait_clk(5);

        apply_stimulus(8'h03, 32'h000010, 3, "read 0x10");
        apply_stimulus(8'h03, 32'h07FFFF, 2, "read wrap");
        apply_stimulus(8'hAB, 32'h000000, 2, "silicon id");
        apply_stimulus(8'h05, 32'h000000, 1, "status");
        apply_stimulus(8'h0B, 32'h000030, 2, "fast read");
        apply_stimulus(8'h5A, 32'h000040, 2, "unknown op");

        // Abort after 12 address bits: no read may be issued.
        rd_log.delete();
        epcs_sce = 1'b0;
        wait_clk(4);
        xfer_byte(8'h03, rx_b);
        xfer_byte(8'h00, rx_b);
        for (int i = 0; i < 4; i++) begin
            epcs_sdo = 1'b0;
            wait_clk(HALF);
            epcs_dclk = 1'b1;
            wait_clk(HALF);
            epcs_dclk = 1'b0;
        end
        wait_clk(HALF);
        epcs_sce = 1'b1;
        wait_clk(8);
        check_output("abort read count", rd_log.size(), 0);
        apply_stimulus(8'h03, 32'h000020, 1, "after abort");

        // Reset in the middle of a data byte of 0xFF.
        epcs_sce = 1'b0;
        wait_clk(4);
        xfer_byte(8'h03, rx_b);
        xfer_byte(8'h00, rx_b);
        xfer_byte(8'h00, rx_b);
        xfer_byte(8'hFF, rx_b);
        for (int i = 0; i < 3; i++) begin
            epcs_sdo = 1'b0;
            wait_clk(HALF);
            epcs_dclk = 1'b1;
            wait_clk(HALF);
            epcs_dclk = 1'b0;
        end
        wait_clk(HALF);
        check_output("pre-reset data0", int'(epcs_data0), 1);
        sys_rst_n = 1'b0;
        #1;
        check_output("in-reset data0", int'(epcs_data0), 0);
        check_output("in-reset mem_rd", int'(mem_rd), 0);
        epcs_sce = 1'b1;
        wait_clk(5);
        sys_rst_n = 1'b1;
        wait_clk(5);
        apply_stimulus(8'h03, 32'h000005, 2, "after reset");

        for (int t = 0; t < 20; t++) begin
            idx = $urandom_range(0, 5);
            op  = op_pool[idx];
            if (idx == 5) op = 8'($urandom);
            apply_stimulus(op, int'($urandom_range(0, 32'hFFFFFF)), int'($urandom_range(1, 3)),
                           $sformatf("rand%0d op%02h", t, op));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
